// File: rtl/ahb_param_arbiter.sv
// ----------------------------------------------------------------------------
// ahb_param_arbiter
//
// Purpose:
//    AHB bus arbiter for NUM_MASTERS requesters. It keeps a one-hot registered
//    grant and moves it only on hready=1 edges. A grant is frozen while the
//    owner holds hlock. It stays frozen for one more hready=1 edge after the
//    owner drops hlock; this is the lock tail. When nothing is requested, the
//    grant returns to DEFAULT_MASTER.
//    hmaster and hmastlock track the address-phase owner one handover behind
//    hgrant.
//
// Configuration macro:
//    AHB_ARB_ROUND_ROBIN_EN
//       defined   : round-robin arbitration. A pointer holds the last winner.
//       undefined : fixed priority; the lowest index wins. No pointer exists.
//
// Parameters:
//    NUM_MASTERS     number of masters (2..16)
//    DEFAULT_MASTER  master parked on when no request is pending
//
// Ports:
//    hclk       in   clock, all state updates on posedge
//    hreset     in   synchronous active-low reset
//    hbusreq    in   [NUM_MASTERS] per-master bus request
//    hlock      in   [NUM_MASTERS] per-master locked-transfer request
//    hready     in   transfer complete; gates arbitration and handover
//    hgrant     out  [NUM_MASTERS] registered one-hot grant
//    hmaster    out  [4] registered address-phase owner index
//    hmastlock  out  registered; address-phase owner is in a locked sequence
// ----------------------------------------------------------------------------
module ahb_param_arbiter #(
   parameter int NUM_MASTERS    = 4,
   parameter int DEFAULT_MASTER = 0
) (
   input  logic                   hclk,
   input  logic                   hreset,
   input  logic [NUM_MASTERS-1:0] hbusreq,
   input  logic [NUM_MASTERS-1:0] hlock,
   input  logic                   hready,
   output logic [NUM_MASTERS-1:0] hgrant,
   output logic [3:0]             hmaster,
   output logic                   hmastlock
);

   localparam logic [3:0]             DEFAULT_IDX   = 4'(DEFAULT_MASTER);
   localparam logic [NUM_MASTERS-1:0] DEFAULT_GRANT =
      {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MASTER;

   // LOCK_HELD : the owner asserted hlock at the last hready edge.
   // LOCK_TAIL : the owner dropped hlock. The grant is held for one more
   //             hready edge.
   typedef enum logic [1:0] {
      LOCK_OPEN = 2'd0,
      LOCK_HELD = 2'd1,
      LOCK_TAIL = 2'd2
   } lock_state_t;

   lock_state_t               state;
   lock_state_t               state_next;
   logic [3:0]                grant_idx;
   logic                      granted_lock;
   logic                      any_req;
   logic                      arb_en;
   logic [3:0]                win_idx;
   logic [NUM_MASTERS-1:0]    win_grant;
   logic [NUM_MASTERS-1:0]    grant_next;

   // Index of the current owner. The grant is one-hot, so the OR-reduction
   // picks out the owner's own lock bit.
   always_comb begin
      grant_idx = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (hgrant[i]) grant_idx = 4'(i);
      end
      granted_lock = |(hlock & hgrant);
      any_req      = |hbusreq;
   end

`ifdef AHB_ARB_ROUND_ROBIN_EN
   logic [3:0] rr_ptr;
   logic [3:0] win_hi;
   logic [3:0] win_any;
   logic       found_hi;

   // Circular search starting after rr_ptr. It takes the lowest requester
   // above the pointer. If there is none, it wraps to the lowest requester
   // overall.
   always_comb begin
      win_hi   = '0;
      win_any  = '0;
      found_hi = 1'b0;
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
         if (hbusreq[i]) begin
            win_any = 4'(i);
            if (4'(i) > rr_ptr) begin
               win_hi   = 4'(i);
               found_hi = 1'b1;
            end
         end
      end
      win_idx = found_hi ? win_hi : win_any;
   end

   // The pointer moves only when a real request wins. Parking on the
   // default master leaves it alone.
   always_ff @(posedge hclk) begin
      if (!hreset) begin
         rr_ptr <= DEFAULT_IDX;
      end else if (hready && arb_en && any_req) begin
         rr_ptr <= win_idx;
      end
   end
`else
   // Fixed priority: a descending scan leaves the lowest requester.
   always_comb begin
      win_idx = '0;
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
         if (hbusreq[i]) win_idx = 4'(i);
      end
   end
`endif

   always_comb begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
         win_grant[i] = (win_idx == 4'(i));
      end
   end

   // Lock tracking and the next grant. This logic only takes effect on
   // hready=1 edges. A live lock always wins, so a re-lock during the tail
   // freezes the grant again.
   always_comb begin
      state_next = state;
      grant_next = hgrant;
      arb_en     = 1'b0;
      if (granted_lock) begin
         state_next = LOCK_HELD;
      end else begin
         case (state)
            LOCK_HELD: state_next = LOCK_TAIL;
            LOCK_TAIL: begin
               state_next = LOCK_OPEN;
               arb_en     = 1'b1;
            end
            default: begin
               state_next = LOCK_OPEN;
               arb_en     = 1'b1;
            end
         endcase
      end
      if (arb_en) begin
         grant_next = any_req ? win_grant : DEFAULT_GRANT;
      end
   end

   always_ff @(posedge hclk) begin
      if (!hreset) begin
         state     <= LOCK_OPEN;
         hgrant    <= DEFAULT_GRANT;
         hmaster   <= DEFAULT_IDX;
         hmastlock <= 1'b0;
      end else if (hready) begin
         state     <= state_next;
         hgrant    <= grant_next;
         hmaster   <= grant_idx;
         hmastlock <= granted_lock;
      end
   end

endmodule

// File: tb/tb_ahb_param_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ahb_param_arbiter
//
// Directed bench for ahb_param_arbiter with NUM_MASTERS=4 and DEFAULT_MASTER=0.
// A table of single-edge records gives the inputs for each cycle and the
// outputs expected after that edge. Hand-written sequences then cover a lock
// tail that spans hready=0 cycles, and reset arriving mid-lock or mid-tail.
// Expectations that differ between the two arbitration modes follow
// AHB_ARB_ROUND_ROBIN_EN.
// ----------------------------------------------------------------------------
module tb_ahb_param_arbiter;

`ifdef AHB_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic       hclk = 1'b0;
   logic       hreset;
   logic [3:0] hbusreq;
   logic [3:0] hlock;
   logic       hready;
   logic [3:0] hgrant;
   logic [3:0] hmaster;
   logic       hmastlock;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic [3:0] lock;
      logic       rdy;
      logic [3:0] g;
      logic [3:0] m;
      logic       ml;
   } vec_t;

   vec_t vecs[$];

   always #5 hclk = ~hclk;

   ahb_param_arbiter #(
      .NUM_MASTERS   (4),
      .DEFAULT_MASTER(0)
   ) dut (
      .hclk     (hclk),
      .hreset   (hreset),
      .hbusreq  (hbusreq),
      .hlock    (hlock),
      .hready   (hready),
      .hgrant   (hgrant),
      .hmaster  (hmaster),
      .hmastlock(hmastlock)
   );

   task automatic add(input logic rst, input logic [3:0] req, input logic [3:0] lock,
                      input logic rdy, input logic [3:0] g, input logic [3:0] m,
                      input logic ml);
      vec_t v;
      v.rst  = rst;
      v.req  = req;
      v.lock = lock;
      v.rdy  = rdy;
      v.g    = g;
      v.m    = m;
      v.ml   = ml;
      vecs.push_back(v);
   endtask

   // Drive the inputs away from the active edge, then sample 1 time unit
   // after it.
   task automatic step(input logic rst, input logic [3:0] req, input logic [3:0] lock,
                       input logic rdy, input logic [3:0] g, input logic [3:0] m,
                       input logic ml, input string tag);
      @(negedge hclk);
      hreset  = rst;
      hbusreq = req;
      hlock   = lock;
      hready  = rdy;
      @(posedge hclk);
      #1;
      n_cmp++;
      if ({hgrant, hmaster, hmastlock} !== {g, m, ml}) begin
         n_err++;
         $display("FAIL %s: got hgrant=%b hmaster=%0d hmastlock=%b, want hgrant=%b hmaster=%0d hmastlock=%b",
                  tag, hgrant, hmaster, hmastlock, g, m, ml);
      end
      n_cmp++;
      if (!$onehot(hgrant)) begin
         n_err++;
         $display("FAIL %s_onehot: got hgrant=%b, want exactly one bit set", tag, hgrant);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no end of test, want finish within time budget");
      $fatal(1, "timeout");
   end

   initial begin
      hreset  = 1'b0;
      hbusreq = 4'b0000;
      hlock   = 4'b0000;
      hready  = 1'b1;

      // Reset, then park on the default master.
      add(0, 4'b0000, 4'b0000, 1, 4'b0001, 4'd0, 0);
      add(0, 4'b0000, 4'b0000, 1, 4'b0001, 4'd0, 0);
      add(1, 4'b0000, 4'b0000, 1, 4'b0001, 4'd0, 0);
      add(1, 4'b0000, 4'b0000, 1, 4'b0001, 4'd0, 0);
      // Masters 1 and 3 both request.
      add(1, 4'b1010, 4'b0000, 1, 4'b0010, 4'd0, 0);
      add(1, 4'b1010, 4'b0000, 1, RR ? 4'b1000 : 4'b0010, 4'd1, 0);
      add(1, 4'b1010, 4'b0000, 1, 4'b0010, RR ? 4'd3 : 4'd1, 0);
      // hready low: grant and hmaster both hold.
      for (int k = 0; k < 4; k++)
         add(1, 4'b0100, 4'b0000, 0, 4'b0010, RR ? 4'd3 : 4'd1, 0);
      add(1, 4'b0100, 4'b0000, 1, 4'b0100, 4'd1, 0);
      // A master-0 request pulse under hready=0 is never sampled.
      add(1, 4'b0001, 4'b0000, 0, 4'b0100, 4'd1, 0);
      add(1, 4'b0100, 4'b0000, 1, 4'b0100, 4'd2, 0);
      // Master 2 locks for 3 edges, then gets one lock-tail edge.
      for (int k = 0; k < 3; k++)
         add(1, 4'b1111, 4'b0100, 1, 4'b0100, 4'd2, 1);
      add(1, 4'b1111, 4'b0000, 1, 4'b0100, 4'd2, 0);
      add(1, 4'b1111, 4'b0000, 1, RR ? 4'b1000 : 4'b0001, 4'd2, 0);
      // All masters request.
      add(1, 4'b1111, 4'b0000, 1, 4'b0001, RR ? 4'd3 : 4'd0, 0);
      add(1, 4'b1111, 4'b0000, 1, RR ? 4'b0010 : 4'b0001, 4'd0, 0);
      add(1, 4'b1111, 4'b0000, 1, RR ? 4'b0100 : 4'b0001, RR ? 4'd1 : 4'd0, 0);
      add(1, 4'b1111, 4'b0000, 1, RR ? 4'b1000 : 4'b0001, RR ? 4'd2 : 4'd0, 0);
      add(1, 4'b1111, 4'b0000, 1, 4'b0001, RR ? 4'd3 : 4'd0, 0);
      add(1, 4'b1111, 4'b0000, 1, RR ? 4'b0010 : 4'b0001, 4'd0, 0);
      // No requests: return to the default master, leaving the pointer at 1.
      add(1, 4'b0000, 4'b0000, 1, 4'b0001, RR ? 4'd1 : 4'd0, 0);
      add(1, 4'b0000, 4'b0000, 1, 4'b0001, 4'd0, 0);
      add(1, 4'b0011, 4'b0000, 1, 4'b0001, 4'd0, 0);
      add(1, 4'b0011, 4'b0000, 1, RR ? 4'b0010 : 4'b0001, 4'd0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].rst, vecs[i].req, vecs[i].lock, vecs[i].rdy,
              vecs[i].g, vecs[i].m, vecs[i].ml, $sformatf("vec%0d", i));
      end

      // Lock tail spanning hready=0 cycles.
      step(0, 4'b0000, 4'b0000, 1, 4'b0001, 4'd0, 0, "tail_rst");
      step(1, 4'b0010, 4'b0000, 1, 4'b0010, 4'd0, 0, "tail_grant1");
      step(1, 4'b0010, 4'b0010, 1, 4'b0010, 4'd1, 1, "tail_lock");
      step(1, 4'b1111, 4'b0000, 0, 4'b0010, 4'd1, 1, "tail_wait0");
      step(1, 4'b1111, 4'b0000, 0, 4'b0010, 4'd1, 1, "tail_wait1");
      step(1, 4'b1111, 4'b0000, 1, 4'b0010, 4'd1, 0, "tail_edge");
      step(1, 4'b1111, 4'b0000, 1, RR ? 4'b0100 : 4'b0001, 4'd1, 0, "tail_rearb");

      // Reset while master 3 holds a lock.
      step(1, 4'b1000, 4'b0000, 1, 4'b1000, RR ? 4'd2 : 4'd0, 0, "lk3_grant");
      step(1, 4'b1000, 4'b1000, 1, 4'b1000, 4'd3, 1, "lk3_lock0");
      step(1, 4'b1000, 4'b1000, 1, 4'b1000, 4'd3, 1, "lk3_lock1");
      step(0, 4'b1000, 4'b1000, 1, 4'b0001, 4'd0, 0, "lk3_reset");
      step(1, 4'b0000, 4'b0000, 1, 4'b0001, 4'd0, 0, "lk3_release");
      step(1, 4'b0010, 4'b0000, 1, 4'b0010, 4'd0, 0, "lk3_rearb");

      // Reset during a lock tail discards the tail.
      step(1, 4'b0010, 4'b0010, 1, 4'b0010, 4'd1, 1, "rt_lock");
      step(1, 4'b0010, 4'b0000, 1, 4'b0010, 4'd1, 0, "rt_tail");
      step(0, 4'b0100, 4'b0000, 1, 4'b0001, 4'd0, 0, "rt_reset");
      step(1, 4'b0100, 4'b0000, 1, 4'b0100, 4'd0, 0, "rt_arb");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
